// File: rtl/mem_io_responder_if.sv
// CPU-to-memory bus: word address, write data, write strobe and registered read data.
// The CPU is the master; the memory/IO responder is the slave.
interface mem_io_responder_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] writedata;
  logic             MEM_WR_S;
  logic [WIDTH-1:0] mem_out;

  modport master (output mem_addr, output writedata, output MEM_WR_S, input mem_out);
  modport slave  (input mem_addr, input writedata, input MEM_WR_S, output mem_out);
endinterface

// File: rtl/mem_io_responder.sv
// Memory responder for the CPU: block RAM plus a small I/O page (LEDs, switches,
// prescaled timer with sticky compare flag). Read data is registered, one clock latency.
module mem_io_responder #(
  parameter int               WIDTH    = 16,
  parameter int               RAM_AW   = 10,
  parameter logic [WIDTH-1:0] IO_BASE  = 16'hFF00,
  parameter int               PRESCALE = 50000
) (
  input  logic                clk,
  input  logic                reset,
  mem_io_responder_if.slave   bus,
  input  logic [9:0]          switches,
  output logic [9:0]          leds,
  output logic                timer_flag
);

  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [WIDTH-1:0] ADDR_LED  = IO_BASE;
  localparam logic [WIDTH-1:0] ADDR_SW   = IO_BASE + WIDTH'(1);
  localparam logic [WIDTH-1:0] ADDR_CNT  = IO_BASE + WIDTH'(2);
  localparam logic [WIDTH-1:0] ADDR_CMP  = IO_BASE + WIDTH'(3);
  localparam logic [WIDTH-1:0] ADDR_STAT = IO_BASE + WIDTH'(4);

  typedef enum logic [2:0] {
    SEL_NONE, SEL_RAM, SEL_LED, SEL_SW, SEL_CNT, SEL_CMP, SEL_STAT
  } sel_e;

  sel_e              sel;
  logic              wr;
  logic [RAM_AW-1:0] ram_idx;
  logic [WIDTH-1:0]  ram [RAM_WORDS];

  logic [WIDTH-1:0] mem_out_q, mem_out_d;
  logic [9:0]       led_q, led_d;
  logic [9:0]       sw_meta_q, sw_meta_d;
  logic [9:0]       sw_sync_q, sw_sync_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             flag_q, flag_d;

  logic             tick;
  logic [WIDTH-1:0] count_inc;
  logic             flag_set, flag_clr;

  assign wr      = bus.MEM_WR_S;
  assign ram_idx = bus.mem_addr[RAM_AW-1:0];

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sel = SEL_NONE;
    if ((bus.mem_addr >> RAM_AW) == '0) begin
      sel = SEL_RAM;
    end else begin
      case (bus.mem_addr)
        ADDR_LED:  sel = SEL_LED;
        ADDR_SW:   sel = SEL_SW;
        ADDR_CNT:  sel = SEL_CNT;
        ADDR_CMP:  sel = SEL_CMP;
        ADDR_STAT: sel = SEL_STAT;
        default:   sel = SEL_NONE;
      endcase
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr && sel == SEL_RAM) ram[ram_idx] <= bus.writedata;
  end

  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    count_inc = count_q + WIDTH'(1);
    count_d   = tick ? count_inc : count_q;

    // Only an increment can raise the flag; a set on the same edge as a clear wins.
    flag_set  = tick && (count_inc == cmp_q);
    flag_clr  = wr && sel == SEL_STAT && bus.writedata[0];
    flag_d    = flag_set | (flag_q & ~flag_clr);

    led_d     = (wr && sel == SEL_LED) ? bus.writedata[9:0] : led_q;
    cmp_d     = (wr && sel == SEL_CMP) ? bus.writedata : cmp_q;
    sw_meta_d = switches;
    sw_sync_d = sw_meta_q;

    // Read data reflects state before this edge, giving read-old-data on collisions.
    case (sel)
      SEL_RAM:  mem_out_d = ram[ram_idx];
      SEL_LED:  mem_out_d = WIDTH'(led_q);
      SEL_SW:   mem_out_d = WIDTH'(sw_sync_q);
      SEL_CNT:  mem_out_d = count_q;
      SEL_CMP:  mem_out_d = cmp_q;
      SEL_STAT: mem_out_d = WIDTH'(flag_q);
      default:  mem_out_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_out_q <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      presc_q   <= '0;
      count_q   <= '0;
      cmp_q     <= '1;
      flag_q    <= 1'b0;
    end else begin
      mem_out_q <= mem_out_d;
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      flag_q    <= flag_d;
    end
  end

  assign bus.mem_out = mem_out_q;
  assign leds        = led_q;
  assign timer_flag  = flag_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with PRESCALE=4: timer sequence, table-driven
// RAM/IO vectors, then an asynchronous reset pulse mid-operation.
module tb_mem_io_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] switches;
  logic [9:0] leds;
  logic       timer_flag;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  mem_io_responder_if #(.WIDTH(16)) bus_if ();

  mem_io_responder #(
    .WIDTH   (16),
    .RAM_AW  (10),
    .IO_BASE (16'hFF00),
    .PRESCALE(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .switches  (switches),
    .leds      (leds),
    .timer_flag(timer_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic [9:0]  sw;
    logic        chk_out;
    logic [15:0] exp_out;
    logic [9:0]  exp_leds;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Drive one bus cycle, then settle just past the rising edge.
  task automatic cyc(input logic [15:0] addr, input logic [15:0] wd, input logic wr);
    bus_if.mem_addr  = addr;
    bus_if.writedata = wd;
    bus_if.MEM_WR_S  = wr;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  initial begin
    logic [15:0] tgt;

    vecs[0]  = '{16'h0005, 16'hBEEF, 1'b1, 10'h000, 1'b0, 16'h0000, 10'h000};
    vecs[1]  = '{16'h0005, 16'h0000, 1'b0, 10'h000, 1'b1, 16'hBEEF, 10'h000};
    vecs[2]  = '{16'h0405, 16'h1111, 1'b1, 10'h000, 1'b1, 16'h0000, 10'h000};
    vecs[3]  = '{16'h0405, 16'h0000, 1'b0, 10'h000, 1'b1, 16'h0000, 10'h000};
    vecs[4]  = '{16'h0005, 16'h0000, 1'b0, 10'h000, 1'b1, 16'hBEEF, 10'h000};
    vecs[5]  = '{16'h0007, 16'h1234, 1'b1, 10'h000, 1'b0, 16'h0000, 10'h000};
    vecs[6]  = '{16'h0007, 16'h5678, 1'b1, 10'h000, 1'b1, 16'h1234, 10'h000};
    vecs[7]  = '{16'h0007, 16'h0000, 1'b0, 10'h000, 1'b1, 16'h5678, 10'h000};
    vecs[8]  = '{16'hFF00, 16'hFFFF, 1'b1, 10'h000, 1'b1, 16'h0000, 10'h3FF};
    vecs[9]  = '{16'hFF00, 16'h0000, 1'b0, 10'h000, 1'b1, 16'h03FF, 10'h3FF};
    vecs[10] = '{16'hFF01, 16'hFFFF, 1'b1, 10'h2A5, 1'b1, 16'h0000, 10'h3FF};
    vecs[11] = '{16'hFF01, 16'h0000, 1'b0, 10'h2A5, 1'b1, 16'h0000, 10'h3FF};
    vecs[12] = '{16'hFF01, 16'h0000, 1'b0, 10'h2A5, 1'b1, 16'h02A5, 10'h3FF};
    vecs[13] = '{16'hFF00, 16'h0000, 1'b0, 10'h2A5, 1'b1, 16'h03FF, 10'h3FF};
    vecs[14] = '{16'h1000, 16'h0000, 1'b0, 10'h2A5, 1'b1, 16'h0000, 10'h3FF};
    vecs[15] = '{16'hFF05, 16'h0001, 1'b1, 10'h2A5, 1'b1, 16'h0000, 10'h3FF};
    vecs[16] = '{16'hFF00, 16'h0155, 1'b1, 10'h2A5, 1'b1, 16'h03FF, 10'h155};
    vecs[17] = '{16'h03FF, 16'hABCD, 1'b1, 10'h2A5, 1'b0, 16'h0000, 10'h155};
    vecs[18] = '{16'h03FF, 16'h0000, 1'b0, 10'h2A5, 1'b1, 16'hABCD, 10'h155};
    vecs[19] = '{16'h0000, 16'h0001, 1'b1, 10'h2A5, 1'b0, 16'h0000, 10'h155};
    vecs[20] = '{16'h03FF, 16'h0000, 1'b0, 10'h2A5, 1'b1, 16'hABCD, 10'h155};
    vecs[21] = '{16'h0000, 16'h0000, 1'b0, 10'h2A5, 1'b1, 16'h0001, 10'h155};

    reset            = 1'b1;
    switches         = '0;
    bus_if.mem_addr  = '0;
    bus_if.writedata = '0;
    bus_if.MEM_WR_S  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_out", bus_if.mem_out, 16'h0000);
    check("rst_leds", leds, 10'h000);
    check("rst_flag", timer_flag, 1'b0);
    reset  = 1'b0;
    edge_n = 0;

    // Timer: compare=3, count reaches 3 and the flag rises on edge 12.
    cyc(16'hFF03, 16'h0003, 1'b1);
    for (int k = 2; k <= 13; k++) begin
      cyc(16'hFF02, 16'h0000, 1'b0);
      check("timer_flag_rise", timer_flag, k >= 12);
      check("timer_count", bus_if.mem_out, (k - 1) / 4);
    end
    cyc(16'hFF04, 16'h0001, 1'b1);
    check("flag_clear", timer_flag, 1'b0);
    cyc(16'hFF03, 16'h0005, 1'b1);
    check("flag_stays_clear", timer_flag, 1'b0);
    for (int k = 16; k <= 19; k++) begin
      cyc(16'hFF02, 16'h0000, 1'b0);
      check("flag_no_reassert", timer_flag, 1'b0);
    end
    // Edge 20: count 4->5 matches compare while status is being cleared.
    cyc(16'hFF04, 16'h0001, 1'b1);
    check("set_beats_clear", timer_flag, 1'b1);
    cyc(16'hFF04, 16'h0001, 1'b1);
    check("flag_clear2", timer_flag, 1'b0);
    cyc(16'hFF03, 16'h0005, 1'b1);
    check("cmp_eq_count_no_set", timer_flag, 1'b0);
    cyc(16'hFF03, 16'h0000, 1'b0);
    check("cmp_readback", bus_if.mem_out, 16'h0005);
    check("cmp_eq_count_no_set2", timer_flag, 1'b0);
    cyc(16'hFF02, 16'h0000, 1'b0);
    check("count_before_e24", bus_if.mem_out, 16'h0005);
    check("no_set_on_mismatch", timer_flag, 1'b0);

    for (int i = 0; i < 22; i++) begin
      switches = vecs[i].sw;
      cyc(vecs[i].addr, vecs[i].wdata, vecs[i].wr);
      if (vecs[i].chk_out) check($sformatf("vec%0d_mem_out", i), bus_if.mem_out, vecs[i].exp_out);
      check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
    end

    // Arm the flag two counts ahead, then pulse reset mid-cycle.
    tgt = 16'(edge_n / 4 + 2);
    cyc(16'hFF03, tgt, 1'b1);
    repeat (8) cyc(16'hFF00, 16'h0000, 1'b0);
    check("pre_rst_flag", timer_flag, 1'b1);
    check("pre_rst_mem_out", bus_if.mem_out, 16'h0155);
    check("pre_rst_leds", leds, 10'h155);

    reset = 1'b1;
    #1;
    check("async_rst_leds", leds, 10'h000);
    check("async_rst_mem_out", bus_if.mem_out, 16'h0000);
    check("async_rst_flag", timer_flag, 1'b0);
    #2;
    reset  = 1'b0;
    edge_n = 0;

    cyc(16'hFF03, 16'h0000, 1'b0);
    check("post_rst_cmp", bus_if.mem_out, 16'hFFFF);
    cyc(16'hFF02, 16'h0000, 1'b0);
    check("post_rst_count", bus_if.mem_out, 16'h0000);
    cyc(16'h0005, 16'h0000, 1'b0);
    check("post_rst_ram5", bus_if.mem_out, 16'hBEEF);
    cyc(16'h0007, 16'h0000, 1'b0);
    check("post_rst_ram7", bus_if.mem_out, 16'h5678);
    cyc(16'hFF00, 16'h0000, 1'b0);
    check("post_rst_led_read", bus_if.mem_out, 16'h0000);
    check("post_rst_flag", timer_flag, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
